// File: rtl/async_fifo_rptr_rempty_v2_pkg.sv
// Shared pointer helpers for the async FIFO: Gray/binary conversion and pointer width.
package async_fifo_pkg;

  localparam int unsigned GRAY_W = 32;

  typedef logic [GRAY_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic gray_word_t gray2bin(gray_word_t g);
    gray_word_t b;
    b = '0;
    for (int unsigned i = 0; i < GRAY_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic int unsigned ptr_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/async_fifo_rptr_rempty_v2_if.sv
// Read-side bundle of the async FIFO: request/flush in, pointers and status out.
interface async_fifo_rptr_rempty_v2_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic          rinc;
  logic          rflush;
  logic [PW-1:0] wptr;
  logic [PW-1:0] ae_thresh;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [PW-1:0] rlevel;
  logic          runderflow;

  modport master (
    output rinc, rflush, wptr, ae_thresh,
    input  raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );

  modport slave (
    input  rinc, rflush, wptr, ae_thresh,
    output raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
  );

endinterface

// File: rtl/async_fifo_rptr_rempty_v2_sync.sv
// Multi-flop synchronizer for a Gray pointer crossing into this clock domain.
module async_fifo_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/async_fifo_rptr_rempty_v2.sv
// Read-domain pointer, empty, level, almost-empty and underflow logic of the async FIFO.
module async_fifo_rptr_rempty_v2
  import async_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        rclk,
  input  logic                        rrst_n,
  async_fifo_rptr_rempty_v2_if.slave  bus
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0] rq_wptr;
  logic [PW-1:0] rq_wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] level_next;
  logic          rd_fire;
  logic          ae_next;

  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rlevel_q;
  logic          rempty_q;
  logic          ralmost_empty_q;
  logic          runderflow_q;

  async_fifo_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d     (bus.wptr),
    .q     (rq_wptr)
  );

  // Flush overrides a same-cycle read; level never exceeds DEPTH, so a
  // threshold at or above DEPTH keeps almost-empty asserted.
  always_comb begin
    rq_wbin = PW'(gray2bin(GRAY_W'(rq_wptr)));
    rd_fire = bus.rinc & ~rempty_q;
    if (bus.rflush) begin
      rbinnext = rq_wbin;
    end else begin
      rbinnext = rbin + PW'(rd_fire);
    end
    rgraynext  = PW'(bin2gray(GRAY_W'(rbinnext)));
    level_next = rq_wbin - rbinnext;
    ae_next    = (level_next <= bus.ae_thresh);
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin            <= '0;
      rptr_q          <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      rlevel_q        <= '0;
      runderflow_q    <= 1'b0;
    end else begin
      rbin            <= rbinnext;
      rptr_q          <= rgraynext;
      rempty_q        <= (rgraynext == rq_wptr);
      ralmost_empty_q <= ae_next;
      rlevel_q        <= level_next;
      runderflow_q    <= runderflow_q | (bus.rinc & rempty_q & ~bus.rflush);
    end
  end

  assign bus.raddr         = rbin[AW-1:0];
  assign bus.rptr          = rptr_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = ralmost_empty_q;
  assign bus.rlevel        = rlevel_q;
  assign bus.runderflow    = runderflow_q;

endmodule

// File: tb/tb_async_fifo_rptr_rempty_v2.sv
// Bench for the read-side pointer block: directed scenarios plus random traffic against an occupancy model.
module tb_async_fifo_rptr_rempty_v2;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned SYNC  = 2;
  localparam int          MOD   = 32;

  logic rclk;
  logic rrst_n;

  async_fifo_rptr_rempty_v2_if #(.DEPTH(DEPTH)) bus ();

  async_fifo_rptr_rempty_v2 #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Write count as seen by the write side, and the model's view of the read side.
  int wcnt = 0;
  int aeth = 3;
  int m_rcnt;
  int m_level;
  bit m_empty;
  bit m_ae;
  bit m_uf;
  int m_pipe [SYNC];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) % MOD;
  endfunction

  task automatic model_edge(input bit rst_v, input bit rinc_v, input bit flush_v);
    int seen;
    if (!rst_v) begin
      m_rcnt = 0; m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;
    end else begin
      seen = m_pipe[SYNC-1];
      if (rinc_v && m_empty && !flush_v) m_uf = 1;
      if (flush_v)                 m_rcnt = seen;
      else if (rinc_v && !m_empty) m_rcnt = (m_rcnt + 1) % MOD;
      m_level = (seen - m_rcnt + MOD) % MOD;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= aeth);
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = wcnt;
    end
  endtask

  task automatic cyc(input bit rst_v, input bit rinc_v, input bit flush_v);
    rrst_n        = rst_v;
    bus.rinc      = rinc_v;
    bus.rflush    = flush_v;
    bus.wptr      = 5'(gray(wcnt));
    bus.ae_thresh = 5'(aeth);
    @(posedge rclk);
    model_edge(rst_v, rinc_v, flush_v);
    #1;
    chk("raddr",  int'(bus.raddr),         m_rcnt % DEPTH);
    chk("rptr",   int'(bus.rptr),          gray(m_rcnt));
    chk("rempty", int'(bus.rempty),        int'(m_empty));
    chk("rlevel", int'(bus.rlevel),        m_level);
    chk("ralmost_empty", int'(bus.ralmost_empty), int'(m_ae));
    chk("runderflow", int'(bus.runderflow), int'(m_uf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rrst_n = 1'b0;
    bus.rinc = 1'b0;
    bus.rflush = 1'b0;
    bus.wptr = '0;
    bus.ae_thresh = 5'd3;
    m_rcnt = 0; m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 0;

    // Reset with wptr toggling
    for (int i = 0; i < 3; i++) begin
      wcnt = (i % 2 == 0) ? 5 : 0;
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("rst_rempty", int'(bus.rempty), 1);
    chk("rst_rlevel", int'(bus.rlevel), 0);

    // Fill to 6 and drain back-to-back
    aeth = 3;
    wcnt = 6;
    cyc(1'b1, 1'b0, 1'b0);
    chk("release_empty1", int'(bus.rempty), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("release_empty2", int'(bus.rempty), 1);
    cyc(1'b1, 1'b0, 1'b0);
    chk("fill_level", int'(bus.rlevel), 6);
    chk("fill_ae", int'(bus.ralmost_empty), 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("drain_empty", int'(bus.rempty), 1);

    // Wrap: 20 entries from a fresh reset
    wcnt = 0;
    cyc(1'b0, 1'b0, 1'b0);
    wcnt = 20;
    idle(3);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("wrap_rptr", int'(bus.rptr), 5'b11110);
    chk("wrap_level", int'(bus.rlevel), 0);

    // Underflow is sticky through valid reads
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("uf_set", int'(bus.runderflow), 1);
    wcnt = 23;
    idle(3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("uf_sticky", int'(bus.runderflow), 1);
    wcnt = 0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("uf_clear", int'(bus.runderflow), 0);

    // Flush at level 7 with a simultaneous read
    wcnt = 2;
    idle(3);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    wcnt = 9;
    idle(3);
    chk("pre_flush_level", int'(bus.rlevel), 7);
    cyc(1'b1, 1'b1, 1'b1);
    chk("flush_raddr", int'(bus.raddr), 9);
    chk("flush_rptr", int'(bus.rptr), 5'b01101);

    // Reset in the middle of a drain
    wcnt = 13;
    idle(3);
    chk("mid_level", int'(bus.rlevel), 4);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("mid_rst_level", int'(bus.rlevel), 0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit rst_v, rinc_v, flush_v;
      rst_v   = ($urandom_range(0, 199) != 0);
      rinc_v  = ($urandom_range(0, 1) == 1);
      flush_v = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) aeth = $urandom_range(0, 31);
      if (!rst_v) wcnt = 0;
      else if (((wcnt - m_rcnt + MOD) % MOD) < DEPTH && $urandom_range(0, 2) != 0)
        wcnt = (wcnt + 1) % MOD;
      cyc(rst_v, rinc_v, flush_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_rptr_rempty_v2.md
Name: async_fifo_rptr_rempty_v2

Overview:
Next-generation read-side pointer and empty logic for the async FIFO, running entirely in the read clock domain. It takes the raw Gray write pointer from the write domain and synchronises it internally through a configurable-depth synchronizer. It produces the binary read address, the Gray read pointer for export to the write domain, and the empty flag. Beyond the previous generation it adds a fill level, a programmable almost-empty flag, a sticky underflow flag, and a read-side flush.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 4. AW = $clog2(DEPTH); pointers are AW+1 bits.
SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; >= 2.

Ports:
rclk  in  1  read clock; the only clock.
rrst_n  in  1  synchronous active-low reset, sampled on rising rclk.
rinc  in  1  read request; consumes one entry when FIFO not empty.
rflush  in  1  discard all visible entries: read pointer jumps to synchronised write pointer.
wptr  in  AW+1  Gray write pointer, asynchronous (write domain).
ae_thresh  in  AW+1  almost-empty threshold, quasi-static.
raddr  out  AW  binary memory read address.
rptr  out  AW+1  registered Gray read pointer, exported to write-domain sync.
rempty  out  1  FIFO empty.
ralmost_empty  out  1  rlevel <= ae_thresh.
rlevel  out  AW+1  entries visible to the read side, 0..DEPTH.
runderflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset applies on a rising rclk with rrst_n=0; nothing is asynchronous. Sync flops, rbin and rptr reset to 0. Outputs reset to: rempty=1, ralmost_empty=1, rlevel=0, runderflow=0, raddr=0. Reset mid-operation discards all state on that edge, with no partial update.
- Synchronizer: wptr passes through SYNC_STAGES flops, giving rq_wptr (Gray). rq_wbin = gray2bin(rq_wptr), combinational.
- rd_fire = rinc & ~rempty.
- rbinnext = rflush ? rq_wbin : rbin + rd_fire, modulo 2^(AW+1). rflush has priority over rinc; rinc in the same cycle is ignored and does not set underflow.
- rgraynext = (rbinnext >> 1) ^ rbinnext. rbin <= rbinnext; rptr <= rgraynext; raddr = rbin[AW-1:0].
- rempty <= (rgraynext == rq_wptr). Compare against the current synchronizer output, not a look-ahead.
- rlevel <= (rq_wbin - rbinnext) mod 2^(AW+1).
- ralmost_empty <= (level_next <= ae_thresh). ae_thresh >= DEPTH forces it to 1.
- runderflow <= runderflow | (rinc & rempty & ~rflush). Cleared only by reset. An underflowing read does not move any pointer.
- Latency:
  - rinc to raddr/rptr/rempty/rlevel update: 1 rclk.
  - wptr change to rempty/rlevel update: SYNC_STAGES+1 rclk edges.
- Wrap-around: pointer MSB toggles each DEPTH reads; raddr wraps DEPTH-1 to 0. Level arithmetic is modulo, so it is correct across wrap.
- Invariant, checked every cycle outside reset: rempty == (rlevel == 0); rlevel <= DEPTH; rptr == bin2gray(rbin).
- rempty deasserts only after write data is synchronised (pessimistic). It asserts in the same cycle the last entry is read.

Decomposition:
- Package async_fifo_pkg: functions bin2gray and gray2bin (parametrised width via a constant-width wrapper), and the helper ptr_w(DEPTH) = $clog2(DEPTH)+1.
- Sub-module async_fifo_sync: WIDTH and STAGES parameters, synchronous active-low reset, plain flop chain. Instantiated once here for wptr; reused by the write side for rptr.

Test Plan:
1. Reset: hold rrst_n=0 for 3 rclk with wptr=5'b00111 toggling -> rempty=1, ralmost_empty=1, rlevel=0, raddr=0, rptr=0, runderflow=0. On release, rempty stays 1 for 2 edges.
2. Fill and drain (DEPTH=16, SYNC_STAGES=2, ae_thresh=3): wptr=gray(6)=5'b00101 -> after 3 edges rempty=0, rlevel=6, ralmost_empty=0. Issue 6 back-to-back rinc -> raddr 0..5, rlevel 5,4,3,2,1,0, ralmost_empty=1 from level 3, rempty=1 after the 6th read.
3. Wrap: step wptr to gray(20)=5'b11110 and read 20 entries -> raddr runs 0..15,0..3; final rptr=5'b11110, rbin MSB=1, rempty=1, rlevel=0.
4. Underflow: rinc=1 while rempty=1 -> raddr/rptr unchanged, runderflow=1 next edge. It stays 1 through subsequent valid reads and clears only on reset.
5. Flush: level 7 (rbin=2, synced wbin=9), assert rflush together with rinc -> next edge raddr=9, rptr=gray(9)=5'b01101, rempty=1, rlevel=0, runderflow=0.
6. Reset mid-drain: at level 4, with rinc high, pulse rrst_n=0 for 1 cycle -> all outputs take reset values on that edge. Reads resume correctly once wptr is resynchronised after 2 further edges.
